// File: rtl/hit_counter_bank.sv
// Per-rule hit statistics: collects rule matches while a packet is in flight.
// It commits them to saturating or wrapping counters on a clean eop, and discards them on error or a lost eop.
// Latency: counters, pkt_hit and pkt_done update on the eop edge; rd_data is one cycle behind rd_sel. There is no backpressure.
module hit_counter_bank #(
    parameter int NUM_RULES = 4,
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 1,
    localparam int SEL_WIDTH = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sop,
    input  logic                           eop,
    input  logic                           valid,
    input  logic [5:0]                     error,
    input  logic [NUM_RULES-1:0]           match,
    input  logic                           clear,
    input  logic [SEL_WIDTH-1:0]           rd_sel,
    output logic [CNT_WIDTH-1:0]           rd_data,
    output logic [NUM_RULES*CNT_WIDTH-1:0] hits_flat,
    output logic [CNT_WIDTH-1:0]           pkt_cnt,
    output logic [CNT_WIDTH-1:0]           drop_cnt,
    output logic                           pkt_done,
    output logic [NUM_RULES-1:0]           pkt_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_RULES-1:0]   pending;
    logic [CNT_WIDTH-1:0]   hits [NUM_RULES];

    logic                   bad;
    logic                   sop_v;
    logic                   eop_v;
    logic [NUM_RULES-1:0]   commit_set;

    logic                   do_commit;
    logic                   do_discard;
    logic                   pend_load;
    logic                   pend_acc;

    assign bad   = |error;
    assign sop_v = sop & valid;
    assign eop_v = eop & valid;
    // pending is always zero in IDLE, so this also covers single-beat packets.
    assign commit_set = pending | match;

    // One increment step, either sticking at all-ones or wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        if ((SATURATE != 0) && (&v))
            return v;
        else
            return v + CNT_WIDTH'(1);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. In PKT, error takes priority, then eop, then a restarting sop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sop_v) begin
                    if (eop)
                        state_nxt = IDLE;
                    else if (bad)
                        state_nxt = DROP;
                    else
                        state_nxt = PKT;
                end
            end
            PKT: begin
                if (bad)
                    state_nxt = eop ? IDLE : DROP;
                else if (eop_v)
                    state_nxt = IDLE;
            end
            DROP: begin
                if (eop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state actions on the datapath: commit, discard, load or accumulate pending.
    always_comb begin
        do_commit  = 1'b0;
        do_discard = 1'b0;
        pend_load  = 1'b0;
        pend_acc   = 1'b0;
        case (state)
            IDLE: begin
                if (sop_v) begin
                    if (eop) begin
                        do_commit  = ~bad;
                        do_discard = bad;
                    end else if (!bad) begin
                        pend_load = 1'b1;
                    end
                end
            end
            PKT: begin
                if (bad) begin
                    do_discard = eop;
                end else if (eop_v) begin
                    do_commit = 1'b1;
                end else if (sop_v) begin
                    // A sop without a preceding eop abandons the open packet and starts a new one.
                    do_discard = 1'b1;
                    pend_load  = 1'b1;
                end else begin
                    pend_acc = 1'b1;
                end
            end
            DROP: begin
                do_discard = eop;
            end
            default: ;
        endcase
    end

    // Pending match set for the packet in flight, plus the per-packet result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pkt_done <= 1'b0;
            pkt_hit  <= '0;
        end else begin
            if (pend_load)
                pending <= match;
            else if (do_commit || do_discard)
                pending <= '0;
            else if (pend_acc)
                pending <= pending | match;

            pkt_done <= do_commit | do_discard;

            if (do_commit)
                pkt_hit <= commit_set;
            else if (do_discard)
                pkt_hit <= '0;
        end
    end

    // Per-rule hit counters; clear overrides a same-cycle commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_RULES; r++)
                hits[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (clear)
                    hits[r] <= '0;
                else if (do_commit && commit_set[r])
                    hits[r] <= cnt_inc(hits[r]);
            end
        end
    end

    // Good and dropped packet counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (do_commit)
                pkt_cnt <= cnt_inc(pkt_cnt);
            if (do_discard)
                drop_cnt <= cnt_inc(drop_cnt);
        end
    end

    // Registered readout; it samples the counters before any same-edge update. Out-of-range selects read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (int'(rd_sel) < NUM_RULES)
            rd_data <= hits[rd_sel];
        else
            rd_data <= '0;
    end

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_flat
        assign hits_flat[g*CNT_WIDTH +: CNT_WIDTH] = hits[g];
    end

endmodule
